// File: rtl/alu_pkg.sv
// Shared constants and state encoding for the serial arithmetic blocks.
package alu_pkg;

  localparam int unsigned NibbleW = 4;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

endpackage

// File: rtl/adder_4bit.sv
// One nibble of ripple addition; the serial adder reuses it every cycle.
module adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
  assign sum   = total[3:0];
  assign cout  = total[4];

endmodule

// File: rtl/serial_adder32.sv
// Nibble-serial add/subtract with ready/valid handshakes on both sides.
// One 4-bit slice per BUSY cycle; result fills from the top down.
module serial_adder32
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned Slices = WIDTH / NibbleW;
  localparam int unsigned CntW   = $clog2(Slices);
  localparam logic [CntW-1:0] CntLast = CntW'(Slices - 1);

  state_e             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               carry_q;
  logic [CntW-1:0]    cnt_q;
  logic [WIDTH-1:0]   result_q;
  logic               cout_q;
  logic               ovf_q;

  logic [NibbleW-1:0] slice_sum;
  logic               slice_cout;

  adder_4bit u_slice (
    .a    (a_q[NibbleW-1:0]),
    .b    (b_q[NibbleW-1:0]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            // Subtraction is a + ~b + 1: invert b here, inject the +1 as carry-in.
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub;
            cnt_q   <= '0;
            state_q <= StBusy;
          end
        end
        StBusy: begin
          result_q <= {slice_sum, result_q[WIDTH-1:NibbleW]};
          a_q      <= a_q >> NibbleW;
          b_q      <= b_q >> NibbleW;
          carry_q  <= slice_cout;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CntLast) begin
            // Top nibble: its MSBs are the operand and sum sign bits.
            cout_q  <= slice_cout;
            ovf_q   <= (a_q[NibbleW-1] == b_q[NibbleW-1]) &&
                       (slice_sum[NibbleW-1] != a_q[NibbleW-1]);
            state_q <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign result    = result_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = (result_q == '0);

endmodule

// File: tb/tb_serial_adder32.sv
// Randomised and directed checks of serial_adder32 against an arithmetic reference model.
module tb_serial_adder32;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        cout;
  logic        ovf;
  logic        zero;

  serial_adder32 #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  int vec  = 0;
  int miss = 0;

  // Plain arithmetic reference: returns {ovf, cout, result}.
  function automatic logic [33:0] ref_op(input logic [31:0] x, input logic [31:0] y,
                                         input logic s);
    logic [32:0] w;
    longint      sr;
    logic        c;
    logic        v;
    if (s) begin
      w  = {1'b0, x} - {1'b0, y};
      c  = (x >= y);
      sr = longint'($signed(x)) - longint'($signed(y));
    end else begin
      w  = {1'b0, x} + {1'b0, y};
      c  = w[32];
      sr = longint'($signed(x)) + longint'($signed(y));
    end
    v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return {v, c, w[31:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Protocol-level model: 0 = idle, 1 = computing, 2 = result presented.
  int          m_st   = 0;
  int          m_left = 0;
  int          n_acc  = 0;
  logic [31:0] e_res;
  logic        e_cout;
  logic        e_ovf;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_st <= 0;
    end else begin
      case (m_st)
        0: if (in_valid) begin
          {e_ovf, e_cout, e_res} <= ref_op(a, b, sub);
          m_left <= 8;
          m_st   <= 1;
          n_acc  <= n_acc + 1;
        end
        1: begin
          m_left <= m_left - 1;
          if (m_left == 1) m_st <= 2;
        end
        2: if (out_ready) m_st <= 0;
        default: m_st <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      vec++;
      if (in_ready !== (m_st == 0) || out_valid !== (m_st == 2)) begin
        miss++;
        $display("FAIL handshake: in_ready=%b out_valid=%b, expected %b %b", in_ready,
                 out_valid, m_st == 0, m_st == 2);
      end else if (m_st == 2 && {result, cout, ovf, zero} !== {e_res, e_cout, e_ovf,
                                                               e_res == 32'd0}) begin
        miss++;
        $display("FAIL result: got %h c%b v%b z%b, expected %h c%b v%b z%b", result, cout,
                 ovf, zero, e_res, e_cout, e_ovf, e_res == 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation from IDLE and check latency, literal outputs and the hold/release.
  task automatic do_op(input string name, input logic [31:0] x, input logic [31:0] y,
                       input logic s, input logic [31:0] er, input logic ec, input logic ev,
                       input logic ez, input int hold);
    int k;
    logic [34:0] snap;
    chk({name, "_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; a = x; b = y; sub = s;
    tick();
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 20) begin
      a = $urandom; b = $urandom; sub = 1'($urandom); in_valid = 1'($urandom);
      tick();
      k++;
    end
    in_valid = 1'b0;
    chk({name, "_latency"}, 64'(k), 64'd8);
    chk({name, "_out"}, 64'({result, cout, ovf, zero}), 64'({er, ec, ev, ez}));
    snap = {result, cout, ovf, zero};
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({name, "_hold"}, 64'({snap, in_ready, out_valid}), 64'({er, ec, ev, ez, 2'b01}));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({name, "_release"}, 64'({in_ready, out_valid}), 64'b10);
  endtask

  initial begin
    int cyc;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_state", 64'({in_ready, out_valid, zero, result}), 64'({3'b101, 32'd0}));
    chk_en = 1'b1;

    chk("model_add_ovf", 64'(ref_op(32'h7FFF_FFFF, 32'h1, 1'b0)), 64'({2'b10, 32'h8000_0000}));
    chk("model_add_wrap", 64'(ref_op(32'hFFFF_FFFF, 32'h1, 1'b0)), 64'({2'b01, 32'h0}));
    chk("model_sub_neg", 64'(ref_op(32'd5, 32'd7, 1'b1)), 64'({2'b00, 32'hFFFF_FFFE}));
    chk("model_sub_ovf", 64'(ref_op(32'h8000_0000, 32'h1, 1'b1)),
        64'({2'b11, 32'h7FFF_FFFF}));

    do_op("add_ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 0);
    do_op("add_wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 3);
    do_op("sub_neg", 32'd5, 32'd7, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1);
    do_op("sub_ovf", 32'h8000_0000, 32'h1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 0);

    // Reset landing in the 4th computing cycle.
    in_valid = 1'b1; a = 32'h1234_5678; b = 32'h1111_1111; sub = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_reset", 64'({in_ready, out_valid, zero, result}), 64'({3'b101, 32'd0}));
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("mid_reset_quiet", 64'(out_valid), 64'd0);
    end
    out_ready = 1'b0;

    // Random traffic with operands churning every cycle.
    cyc = 0;
    while (n_acc < 1005 && cyc < 60000) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = 1'($urandom);
      case ($urandom_range(0, 7))
        0: begin a = 32'h7FFF_FFFF; b = $urandom; end
        1: begin a = 32'h8000_0000; b = $urandom_range(0, 3); end
        2: begin a = $urandom; b = a; end
        3: begin a = $urandom; b = ~a; end
        default: begin a = $urandom; b = $urandom; end
      endcase
      sub = 1'($urandom);
      tick();
      cyc++;
    end
    chk("random_progress", 64'(n_acc >= 1005), 64'd1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
